// File: rtl/decryption_cfg_arbiter.sv
// Round-robin arbiter/sequencer that lets a host port and a key loader share
// the decryption register bank access port, one transaction at a time.

module decryption_cfg_arbiter_port #(
  parameter int reg_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fire_i,
  input  logic [reg_width-1:0] rdata_i,
  input  logic                 err_i,
  output logic                 ack_o,
  output logic [reg_width-1:0] rdata_o,
  output logic                 err_o
);
  logic                 ack_q, ack_d;
  logic [reg_width-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  // Response fields are zero on every cycle except this port's ack cycle.
  always_comb begin
    ack_d   = fire_i;
    rdata_d = fire_i ? rdata_i : '0;
    err_d   = fire_i & err_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
endmodule

module decryption_cfg_arbiter #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [reg_width-1:0]  wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [reg_width-1:0]  wdata1,
  output logic                  ack0,
  output logic [reg_width-1:0]  rdata0,
  output logic                  err0,
  output logic                  ack1,
  output logic [reg_width-1:0]  rdata1,
  output logic                  err1,
  output logic                  busy,
  output logic [addr_width-1:0] m_addr,
  output logic                  m_read,
  output logic                  m_write,
  output logic [reg_width-1:0]  m_wdata,
  input  logic [reg_width-1:0]  m_rdata,
  input  logic                  m_done,
  input  logic                  m_error
);
  localparam int NUM_PORTS = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [reg_width-1:0]  wdata;
  } cfg_req_t;

  logic     [NUM_PORTS-1:0] req_v;
  cfg_req_t [NUM_PORTS-1:0] req_pkt;

  assign req_v      = {req1, req0};
  assign req_pkt[0] = {we0, addr0, wdata0};
  assign req_pkt[1] = {we1, addr1, wdata1};

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  cfg_req_t   txn_q, txn_d;
  logic [7:0] cnt_q, cnt_d;
  logic       m_read_q, m_read_d;
  logic       m_write_q, m_write_d;
  logic       busy_q, busy_d;

  logic                 grant;
  logic                 timeout_hit;
  logic                 rsp_fire;
  logic                 rsp_err;
  logic [reg_width-1:0] rsp_rdata;

  always_comb begin
    // On a tie the port that did not win last time gets the grant.
    grant       = (&req_v) ? ~last_q : req_v[1];
    timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
    rsp_fire    = (state_q == S_WAIT) && (m_done || timeout_hit);
    rsp_err     = m_done ? m_error : 1'b1;
    rsp_rdata   = (m_done && !txn_q.we) ? m_rdata : '0;

    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    txn_d     = txn_q;
    cnt_d     = cnt_q;
    m_read_d  = 1'b0;
    m_write_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_v) begin
          owner_d   = grant;
          txn_d     = req_pkt[grant];
          m_write_d = req_pkt[grant].we;
          m_read_d  = ~req_pkt[grant].we;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_fire) state_d = S_RESP;
        else          cnt_d   = cnt_q + 8'd1;
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      txn_q     <= '0;
      cnt_q     <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      txn_q     <= txn_d;
      cnt_q     <= cnt_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = txn_q.addr;
  assign m_wdata = txn_q.wdata;

  logic [NUM_PORTS-1:0]                ack_v, err_v;
  logic [NUM_PORTS-1:0][reg_width-1:0] rdata_v;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    decryption_cfg_arbiter_port #(.reg_width(reg_width)) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .fire_i  (rsp_fire && (owner_q == 1'(i))),
      .rdata_i (rsp_rdata),
      .err_i   (rsp_err),
      .ack_o   (ack_v[i]),
      .rdata_o (rdata_v[i]),
      .err_o   (err_v[i])
    );
  end

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
  assign err0   = err_v[0];
  assign err1   = err_v[1];
endmodule
